clock_manager: RTL and testbench

- Post-PLL clock and reset manager. Runs on the PLL output clock and consumes the PLL lock flag.
- Holds the design in reset until lock has been stable for a programmable time, then releases a synchronous system reset.
- Generates NUM_EN independent clock-enable strobes, each with its own parameterised divisor.
- Detects loss of lock, reasserts reset, and keeps a sticky flag plus a saturating loss counter for debug.

---
 rtl/clock_manager.sv | 153 +++++++++++++++
 tb/tb_clock_manager.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/clock_manager.sv
// Post-PLL clock and reset manager: synchronises the PLL lock flag, qualifies it for
// LOCK_CYCLES, releases a registered system reset and generates divided clock enables.
module clock_manager #(
    parameter int                          NUM_EN      = 2,
    parameter int                          DIV_WIDTH   = 16,
    parameter logic [NUM_EN*DIV_WIDTH-1:0] DIVISORS    = {16'd4, 16'd2},
    parameter int                          LOCK_CYCLES = 1024,
    parameter int                          SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              locked,
    input  logic              clear_lost,
    output logic              sys_resetn,
    output logic              ready,
    output logic [NUM_EN-1:0] ce,
    output logic              lock_lost,
    output logic [7:0]        lost_count
);

    localparam int            CW        = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CW-1:0] STAB_LAST = CW'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic [CW-1:0]          stab_q, stab_d;
    logic                   loss_ev;
    logic                   sys_resetn_q;
    logic                   lock_lost_q, lock_lost_d;
    logic [7:0]             lost_count_q, lost_count_d;

    // locked is asynchronous to clk; only the last synchroniser stage is used.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= WAIT_LOCK;
            stab_q       <= '0;
            sys_resetn_q <= 1'b0;
            lock_lost_q  <= 1'b0;
            lost_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            stab_q       <= stab_d;
            sys_resetn_q <= (state_d == RUN);
            lock_lost_q  <= lock_lost_d;
            lost_count_q <= lost_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        loss_ev = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                    stab_d  = '0;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    stab_d  = '0;
                end else if (stab_q == STAB_LAST) begin
                    state_d = RUN;
                    stab_d  = '0;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    loss_ev = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                stab_d  = '0;
            end
        endcase
    end

    // A loss in the same cycle as clear_lost wins and restarts the count at 1.
    always_comb begin
        lock_lost_d  = lock_lost_q;
        lost_count_d = lost_count_q;
        if (loss_ev) begin
            lock_lost_d  = 1'b1;
            lost_count_d = clear_lost ? 8'd1
                         : (lost_count_q == 8'hff) ? lost_count_q : lost_count_q + 8'd1;
        end else if (clear_lost) begin
            lock_lost_d  = 1'b0;
            lost_count_d = 8'd0;
        end
    end

    // Counter holds (k-1) mod DIV during RUN cycle k, so the strobe for cycle k is
    // registered on the edge that starts that cycle.
    for (genvar i = 0; i < NUM_EN; i++) begin : g_ch
        localparam logic [DIV_WIDTH-1:0] DIV    = DIVISORS[i*DIV_WIDTH +: DIV_WIDTH];
        localparam logic [DIV_WIDTH-1:0] DIV_M1 = DIV - 1'b1;

        logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
        logic                 ce_q, ce_d;

        always_comb begin
            cnt_d = '0;
            ce_d  = 1'b0;
            if ((state_d == RUN) && (DIV != '0)) begin
                if ((state_q == RUN) && (cnt_q != DIV_M1)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                ce_d = (cnt_d == DIV_M1);
            end
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                cnt_q <= '0;
                ce_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                ce_q  <= ce_d;
            end
        end

        assign ce[i] = ce_q;
    end

    assign sys_resetn = sys_resetn_q;
    assign ready      = (state_q == RUN);
    assign lock_lost  = lock_lost_q;
    assign lost_count = lost_count_q;

endmodule

// File: tb/tb_clock_manager.sv
// Directed bench for clock_manager: SYNC_STAGES=2, LOCK_CYCLES=8, divisors {0,1,3}.
module tb_clock_manager;

    localparam int W = 14;  // {sys_resetn, ready, ce[2:0], lock_lost, lost_count[7:0]}

    logic       clk;
    logic       resetn;
    logic       locked;
    logic       clear_lost;
    logic       sys_resetn;
    logic       ready;
    logic [2:0] ce;
    logic       lock_lost;
    logic [7:0] lost_count;

    logic [W-1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           n_mon = 0;
    int           exp_cnt = 0;
    logic         exp_ll = 1'b0;

    clock_manager #(
        .NUM_EN     (3),
        .DIV_WIDTH  (16),
        .DIVISORS   ({16'd0, 16'd1, 16'd3}),
        .LOCK_CYCLES(8),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .locked    (locked),
        .clear_lost(clear_lost),
        .sys_resetn(sys_resetn),
        .ready     (ready),
        .ce        (ce),
        .lock_lost (lock_lost),
        .lost_count(lost_count)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard helpers ----------------
    function automatic logic [W-1:0] outs();
        return {sys_resetn, ready, ce, lock_lost, lost_count};
    endfunction

    function automatic logic [W-1:0] ev_reset();
        return {1'b0, 1'b0, 3'b000, exp_ll, exp_cnt[7:0]};
    endfunction

    // RUN cycle k: ch0 divides by 3, ch1 by 1, ch2 disabled.
    function automatic logic [W-1:0] ev_run(input int k);
        logic c0;
        c0 = ((k % 3) == 0);
        return {1'b1, 1'b1, 1'b0, 1'b1, c0, exp_ll, exp_cnt[7:0]};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h (srst=%b rdy=%b ce=%b ll=%b cnt=%0d) want %h",
                     name, act, act[13], act[12], act[11:9], act[8], act[7:0], exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            n_mon++;
            check($sformatf("outputs#%0d", n_mon), outs(), e);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic lk, input logic clr, input logic [W-1:0] exp);
        locked     = lk;
        clear_lost = clr;
        @(posedge clk);
        exp_q.push_back(exp);
        @(negedge clk);
        clear_lost = 1'b0;
    endtask

    // Lock rises before edge 1; outputs stay in reset through edge 10.
    task automatic lock_seq();
        for (int e = 1; e <= 10; e++) step(1'b1, 1'b0, ev_reset());
    endtask

    task automatic run_k(input int k_from, input int k_to);
        for (int k = k_from; k <= k_to; k++) step(1'b1, 1'b0, ev_run(k));
    endtask

    // Lock drops after RUN cycle k: two more RUN cycles, loss registered on the third edge.
    task automatic drop(input int k, input logic clr);
        step(1'b0, 1'b0, ev_run(k + 1));
        step(1'b0, 1'b0, ev_run(k + 2));
        exp_ll  = 1'b1;
        exp_cnt = clr ? 1 : ((exp_cnt == 255) ? 255 : exp_cnt + 1);
        step(1'b0, clr, ev_reset());
    endtask

    // ---------------- stimulus ----------------
    initial begin
        resetn     = 1'b0;
        locked     = 1'b0;
        clear_lost = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", outs(), 14'h0);
        resetn = 1'b1;

        // Power-up release, then loss at k=4.
        lock_seq();
        run_k(1, 4);
        drop(4, 1'b0);

        // Re-lock: phase restarts, ch0 fires at k=3,6,9.
        lock_seq();
        run_k(1, 9);

        // Build lost_count=2, then collide clear_lost with a loss.
        drop(9, 1'b0);
        lock_seq();
        run_k(1, 2);
        drop(2, 1'b1);
        check("collision_cnt", {7'd0, lock_lost, lost_count}, {7'd0, 1'b1, 8'd1});
        lock_seq();
        run_k(1, 3);

        // Asynchronous reset between edges while in RUN with loss history.
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset", outs(), 14'h0);
        exp_ll  = 1'b0;
        exp_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        lock_seq();
        run_k(1, 3);

        // Saturation: 260 loss/re-lock cycles.
        for (int n = 0; n < 260; n++) begin
            drop((n == 0) ? 3 : 1, 1'b0);
            lock_seq();
            run_k(1, 1);
        end
        drop(1, 1'b0);
        check("saturated_cnt", {6'd0, lost_count}, {6'd0, 8'd255});
        exp_ll  = 1'b0;
        exp_cnt = 0;
        step(1'b0, 1'b1, ev_reset());

        // Unstable lock: high 5 cycles, low 2, then high; release 11 edges after re-rise.
        for (int e = 1; e <= 5; e++) step(1'b1, 1'b0, ev_reset());
        for (int e = 6; e <= 7; e++) step(1'b0, 1'b0, ev_reset());
        for (int e = 8; e <= 17; e++) step(1'b1, 1'b0, ev_reset());
        run_k(1, 3);

        @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
